decimation_enable_scheduler: RTL and testbench

Sequences the clock enables of a two-stage decimation chain: a stage-1 decimator followed by a stage-2 decimator.
- Both stages run from the same fast clock.
- Generates stage-1 and stage-2 enable pulses with run-time programmable ratios.
- Ratio changes take effect only on stage-2 (output frame) boundaries.
- Gives start/stop control with graceful drain, so the downstream filters never see a truncated output period.

---
 rtl/decimation_enable_scheduler.sv | 161 ++++++++++++++++
 tb/tb_decimation_enable_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/decimation_enable_scheduler.sv
// Enable scheduler for a two-stage decimation chain running on one fast clock.
// Stage-1 pulses every active_r1 clk cycles and stage-2 pulses every active_r2
// stage-1 pulses. New ratios are applied only on stage-2 (frame) boundaries
// while running. Stopping drains to the end of the current output frame.
module decimation_enable_scheduler #(
    parameter int CNT_WIDTH  = 8,
    parameter int R1_DEFAULT = 100,
    parameter int R2_DEFAULT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [CNT_WIDTH-1:0] ratio1,
    input  logic [CNT_WIDTH-1:0] ratio2,
    input  logic                 cfg_load,
    output logic                 cfg_ack,
    output logic                 clk_enable_stage1,
    output logic                 clk_enable_stage2,
    output logic                 busy,
    output logic                 cfg_pending
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] R1_DEF = CNT_WIDTH'(R1_DEFAULT);
    localparam logic [CNT_WIDTH-1:0] R2_DEF = CNT_WIDTH'(R2_DEFAULT);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
    logic [CNT_WIDTH-1:0] cnt2_q, cnt2_d;
    logic [CNT_WIDTH-1:0] active_r1_q, active_r1_d;
    logic [CNT_WIDTH-1:0] active_r2_q, active_r2_d;
    logic [CNT_WIDTH-1:0] pend_r1_q, pend_r1_d;
    logic [CNT_WIDTH-1:0] pend_r2_q, pend_r2_d;
    logic                 pending_q, pending_d;
    logic                 ack_q, ack_d;

    logic [CNT_WIDTH-1:0] eff_r1;
    logic [CNT_WIDTH-1:0] eff_r2;
    logic                 stage1_hit;
    logic                 stage2_hit;

    // A ratio of zero behaves like one; enables are a decode of registered counters.
    always_comb begin
        eff_r1     = (active_r1_q == '0) ? ONE : active_r1_q;
        eff_r2     = (active_r2_q == '0) ? ONE : active_r2_q;
        stage1_hit = (state_q != IDLE) && (cnt1_q == eff_r1 - ONE);
        stage2_hit = stage1_hit && (cnt2_q == eff_r2 - ONE);
    end

    // Next-state: state sequencing, period counting and config handover.
    always_comb begin
        state_d     = state_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        active_r1_d = active_r1_q;
        active_r2_d = active_r2_q;
        pend_r1_d   = pend_r1_q;
        pend_r2_d   = pend_r2_q;
        pending_d   = pending_q;
        ack_d       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt1_d = '0;
                cnt2_d = '0;
                // Nothing is running, so a load takes effect immediately.
                if (cfg_load) begin
                    active_r1_d = ratio1;
                    active_r2_d = ratio2;
                    ack_d       = 1'b1;
                end
                if (run) begin
                    state_d = RUN;
                end
            end

            RUN, DRAIN: begin
                if (stage1_hit) begin
                    cnt1_d = '0;
                    cnt2_d = stage2_hit ? '0 : cnt2_q + ONE;
                end else begin
                    cnt1_d = cnt1_q + ONE;
                end

                // Only a config already pending before this boundary is applied.
                if (stage2_hit && pending_q) begin
                    active_r1_d = pend_r1_q;
                    active_r2_d = pend_r2_q;
                    pending_d   = 1'b0;
                    ack_d       = 1'b1;
                end

                // A load (even on a boundary) waits for the next boundary.
                if (cfg_load) begin
                    pend_r1_d = ratio1;
                    pend_r2_d = ratio2;
                    pending_d = 1'b1;
                end

                // Re-raising run while draining keeps the frame going untouched,
                // and it wins over drain completion on the same cycle.
                if (state_q == RUN) begin
                    if (!run) begin
                        state_d = DRAIN;
                    end
                end else if (run) begin
                    state_d = RUN;
                end else if (stage2_hit) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt1_d  = '0;
                cnt2_d  = '0;
            end
        endcase
    end

    // State register with synchronous reset to defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            active_r1_q <= R1_DEF;
            active_r2_q <= R2_DEF;
            pend_r1_q   <= '0;
            pend_r2_q   <= '0;
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            active_r1_q <= active_r1_d;
            active_r2_q <= active_r2_d;
            pend_r1_q   <= pend_r1_d;
            pend_r2_q   <= pend_r2_d;
            pending_q   <= pending_d;
            ack_q       <= ack_d;
        end
    end

    // Pulses are suppressed during the reset cycle itself.
    always_comb begin
        clk_enable_stage1 = stage1_hit && !rst;
        clk_enable_stage2 = stage2_hit && !rst;
        cfg_ack           = ack_q && !rst;
        busy              = (state_q != IDLE);
        cfg_pending       = pending_q;
    end

endmodule

// File: tb/tb_decimation_enable_scheduler.sv
// Scoreboard bench: a frame-position reference model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_decimation_enable_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] ratio1;
    logic [7:0] ratio2;
    logic       cfg_load;
    logic       cfg_ack;
    logic       clk_enable_stage1;
    logic       clk_enable_stage2;
    logic       busy;
    logic       cfg_pending;

    decimation_enable_scheduler #(
        .CNT_WIDTH (8),
        .R1_DEFAULT(100),
        .R2_DEFAULT(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .run              (run),
        .ratio1           (ratio1),
        .ratio2           (ratio2),
        .cfg_load         (cfg_load),
        .cfg_ack          (cfg_ack),
        .clk_enable_stage1(clk_enable_stage1),
        .clk_enable_stage2(clk_enable_stage2),
        .busy             (busy),
        .cfg_pending      (cfg_pending)
    );

    always #5 clk = ~clk;

    // Expected {cfg_ack, stage1, stage2, busy, cfg_pending} per cycle.
    logic [4:0] exp_q[$];
    int         exp_cyc_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    // Reference model: position within the current output frame, not counters.
    int m_state;   // 0 idle, 1 run, 2 drain
    int m_pos;     // clk cycles elapsed in current frame while active
    int m_ar1, m_ar2, m_pr1, m_pr2;
    bit m_pend, m_ack;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pos = 0;
        m_ar1 = 100; m_ar2 = 4;
        m_pr1 = 0; m_pr2 = 0;
        m_pend = 0; m_ack = 0;
    endtask

    // One clk cycle: drive inputs, predict this cycle's outputs, advance model.
    task automatic step(input bit r, input bit rn, input bit ld, input int r1, input int r2);
        int  p1, p2;
        bit  f1, f2;
        @(posedge clk);
        #1;
        rst = r; run = rn; cfg_load = ld;
        ratio1 = 8'(r1); ratio2 = 8'(r2);
        cyc++;
        p1 = eff(m_ar1);
        p2 = eff(m_ar2);
        f1 = (m_state != 0) && (((m_pos + 1) % p1) == 0);
        f2 = (m_state != 0) && ((m_pos + 1) == p1 * p2);
        exp_q.push_back({m_ack && !r, f1 && !r, f2 && !r, m_state != 0, m_pend});
        exp_cyc_q.push_back(cyc);
        if (r) begin
            model_reset();
        end else begin
            m_ack = 0;
            if (m_state == 0) begin
                m_pos = 0;
                if (ld) begin m_ar1 = r1; m_ar2 = r2; m_ack = 1; end
                if (rn) m_state = 1;
            end else begin
                if (f2) begin
                    m_pos = 0;
                    if (m_pend) begin m_ar1 = m_pr1; m_ar2 = m_pr2; m_pend = 0; m_ack = 1; end
                end else begin
                    m_pos++;
                end
                if (ld) begin m_pr1 = r1; m_pr2 = r2; m_pend = 1; end
                if (m_state == 1) begin
                    if (!rn) m_state = 2;
                end else if (rn) begin
                    m_state = 1;
                end else if (f2) begin
                    m_state = 0;
                end
            end
        end
    endtask

    task automatic idle_n(input int n, input bit rn);
        for (int i = 0; i < n; i++) step(0, rn, 0, 0, 0);
    endtask

    // Monitor: pops one prediction per cycle and compares mid-cycle.
    always @(negedge clk) begin
        logic [4:0] e, a;
        int         c;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            a = {cfg_ack, clk_enable_stage1, clk_enable_stage2, busy, cfg_pending};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d ack/e1/e2/busy/pend actual=%b required=%b", c, a, e);
            end
        end
    end

    initial begin
        int wait_cnt;
        bit rn;
        rst = 1; run = 0; cfg_load = 0; ratio1 = 0; ratio2 = 0;
        model_reset();
        repeat (3) @(posedge clk);

        // Defaults: stage-1 every 100, stage-2 every 400.
        step(1, 0, 0, 0, 0);
        idle_n(900, 1);

        // Idle load of 0/3 then run: stage-1 every cycle, stage-2 every 3.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 3);
        idle_n(20, 1);

        // Load during run at cycle 150; applied at the 400 boundary.
        step(1, 0, 0, 0, 0);
        idle_n(150, 1);
        step(0, 1, 1, 10, 2);
        idle_n(300, 1);

        // Load exactly on the 400 boundary; applied at 800.
        step(1, 0, 0, 0, 0);
        idle_n(400, 1);
        step(0, 1, 1, 10, 2);
        idle_n(420, 1);

        // Drop run at 250: drain to 400 then idle.
        step(1, 0, 0, 0, 0);
        idle_n(250, 1);
        idle_n(170, 0);

        // Drop at 250, re-raise at 300: frame continues undisturbed.
        step(1, 0, 0, 0, 0);
        idle_n(250, 1);
        idle_n(50, 0);
        idle_n(520, 1);

        // Reset mid-run with a pending config.
        step(1, 0, 0, 0, 0);
        idle_n(150, 1);
        step(0, 1, 1, 10, 2);
        idle_n(99, 1);
        step(1, 1, 0, 0, 0);
        idle_n(60, 0);

        // Idle load coincident with run rising.
        step(0, 1, 1, 3, 2);
        idle_n(30, 1);
        idle_n(20, 0);

        // Random traffic with small ratios to hit boundary coincidences.
        rn = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 39) == 0) rn = ~rn;
            step($urandom_range(0, 399) == 0, rn, $urandom_range(0, 24) == 0,
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 5)));
        end
        idle_n(5, 0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
